seg_led_scan: RTL

SEG_LED_SCAN -- requirements
Module: seg_led_scan

---
 rtl/seg_led_scan.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_led_scan.sv
// ---------------------------------------------------------------------------
// seg_led_scan
//   Six-digit multiplexed common-anode seven-segment driver. A 20-bit binary
//   value is converted to BCD with a sequential double-dabble engine
//   (IDLE -> SHIFT x20 -> DONE) and latched into a display register. A scan
//   divider walks the digit index 0..5, and the registered outputs drive one
//   active-low digit select with its active-low segment pattern.
//
// Parameters
//   SCAN_DIV  clk cycles per digit slot (legal 2..65535)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   data     in   [19:0] unsigned value, saturated to 999999
//   point    in   [5:0]  decimal point per digit
//   en       in   display enable (scan and conversion keep running when low)
//   sign     in   show a minus sign
//   seg_sel  out  [5:0]  digit select, active-low, bit 0 = rightmost digit
//   seg_led  out  [7:0]  segments, active-low, bit7 = dp, bits 6..0 = g..a
//
// Configuration macro
//   SEG_LED_SCAN_ZERO_BLANK_EN  blank leading zeros; the minus sign sits
//                               just left of the most significant digit
// ---------------------------------------------------------------------------
module seg_led_scan #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        en,
  input  logic        sign,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] CODE_MINUS = 8'hBF;
  localparam logic [7:0] CODE_BLANK = 8'hFF;

  state_t      state_r;
  logic        first_r;     // forces one conversion after reset
  logic [19:0] last_r;      // raw value of the last conversion started
  logic [43:0] shift_r;     // {bcd[23:0], bin[19:0]} double-dabble workspace
  logic [4:0]  step_r;
  logic [23:0] disp_r;      // six BCD digits currently displayed

  logic [15:0] div_r;
  logic [2:0]  dig_idx_r;

  logic [3:0]  nib_s;
  logic [2:0]  msd_s;
  logic [7:0]  code_s;
  logic [7:0]  led_s;

  // Clamp the input to what six decimal digits can show.
  function automatic logic [19:0] saturate(input logic [19:0] v);
    return (v > 20'd999999) ? 20'd999999 : v;
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [43:0] dd_step(input logic [43:0] v);
    logic [43:0] t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      if (t[20 + 4*i +: 4] >= 4'd5) begin
        t[20 + 4*i +: 4] = t[20 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[42:0], 1'b0};
  endfunction

  // BCD digit to active-low segment pattern, dp off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = CODE_BLANK;
    endcase
    return c;
  endfunction

  // Conversion FSM: latch on change, 20 shift steps, then publish the BCD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      first_r <= 1'b1;
      last_r  <= 20'd0;
      shift_r <= 44'd0;
      step_r  <= 5'd0;
      disp_r  <= 24'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (first_r || (data != last_r)) begin
            state_r <= SHIFT;
            first_r <= 1'b0;
            last_r  <= data;
            shift_r <= {24'd0, saturate(data)};
            step_r  <= 5'd0;
          end
        end
        SHIFT: begin
          shift_r <= dd_step(shift_r);
          step_r  <= step_r + 5'd1;
          if (step_r == 5'd19) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          disp_r  <= shift_r[43:20];
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Scan divider and digit index; both free-run regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r     <= 16'd0;
      dig_idx_r <= 3'd0;
    end else if (div_r == (SCAN_DIV - 16'd1)) begin
      div_r     <= 16'd0;
      dig_idx_r <= (dig_idx_r == 3'd5) ? 3'd0 : dig_idx_r + 3'd1;
    end else begin
      div_r     <= div_r + 16'd1;
    end
  end

  // Most significant nonzero digit; stays 0 for value 0 so digit 0 shows "0".
  always_comb begin
    msd_s = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (disp_r[4*i +: 4] != 4'd0) begin
        msd_s = 3'(i);
      end
    end
  end

  // Segment pattern of the current digit, including sign, blanking and dp.
  always_comb begin
    nib_s = disp_r[{dig_idx_r, 2'b00} +: 4];
`ifdef SEG_LED_SCAN_ZERO_BLANK_EN
    if (dig_idx_r > msd_s) begin
      if (sign && (dig_idx_r == (msd_s + 3'd1))) begin
        code_s = CODE_MINUS;
      end else begin
        code_s = CODE_BLANK;
      end
    end else if (sign && (msd_s == 3'd5) && (dig_idx_r == 3'd5)) begin
      // no room left of a six-digit value: minus overrides the top digit
      code_s = CODE_MINUS;
    end else begin
      code_s = seg_code(nib_s);
    end
`else
    if (sign && (dig_idx_r == 3'd5)) begin
      code_s = CODE_MINUS;
    end else begin
      code_s = seg_code(nib_s);
    end
`endif
    led_s = {code_s[7] & ~point[dig_idx_r], code_s[6:0]};
  end

  // Registered digit select and segment outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sel <= 6'h3F;
      seg_led <= 8'hFF;
    end else if (en) begin
      seg_sel <= ~(6'd1 << dig_idx_r);
      seg_led <= led_s;
    end else begin
      seg_sel <= 6'h3F;
      seg_led <= 8'hFF;
    end
  end

endmodule
